key_autorepeat: RTL
===================

KEY_AUTOREPEAT -- requirements
Module: key_autorepeat

Interface
REQ-001 Parameter DELAY_CNT, default 50_000_000, hold time before first repeat in clock cycles (500 ms at 10 ns).
REQ-002 Parameter RATE_CNT, default 10_000_000, repeat period in clock cycles (100 ms at 10 ns).
REQ-003 Parameter CNT_W, default 26, counter width; SHALL hold max(DELAY_CNT, RATE_CNT)-1.
REQ-004 reloj  in  1  system clock, single clock domain, rising edge.
REQ-005 resetM  in  1  reset, synchronous, active-high.
REQ-006 sw_db  in  1  debounced key level from the debounce stage (sw_o), already synchronous to reloj.
REQ-007 en  in  1  auto-repeat enable; 0 = press/release events only.
REQ-008 evt_tick  out  1  one-cycle pulse per press and per repeat; drives field increment.
REQ-009 press_tick  out  1  one-cycle pulse on key press.
REQ-010 release_tick  out  1  one-cycle pulse on key release.
REQ-011 held  out  1  level, high while in REPEAT state.
REQ-012 rep_cnt  out  8  repeats since last press, saturating.

Function
REQ-013 All outputs SHALL be registered; sw_db SHALL be sampled into sw_q each cycle for edge detection.
REQ-014 Rise = sw_db & ~sw_q; fall = ~sw_db & sw_q is not used; release SHALL be decided by state plus sw_db==0.
REQ-015 States: IDLE, HOLD, REPEAT; one-hot or binary encoding per package.
REQ-016 IDLE: on rise -> HOLD, cnt<=0, rep_cnt<=0, press_tick=1 and evt_tick=1 in the next cycle.
REQ-017 HOLD: sw_db==0 -> IDLE with release_tick=1; else if cnt==DELAY_CNT-1 and en==1 -> REPEAT, cnt<=0, evt_tick=1, rep_cnt+1; else cnt+1, saturating at DELAY_CNT-1.
REQ-018 HOLD with en==0 SHALL remain in HOLD with cnt saturated; raising en SHALL enter REPEAT on the next edge.
REQ-019 REPEAT: sw_db==0 -> IDLE with release_tick=1; else if en==0 -> cnt held, no ticks; else if cnt==RATE_CNT-1 -> cnt<=0, evt_tick=1, rep_cnt+1; else cnt+1.
REQ-020 rep_cnt SHALL saturate at 255; evt_tick SHALL still pulse after saturation.
REQ-021 Release SHALL take priority over a repeat tick falling due in the same cycle; no evt_tick then.
REQ-022 press_tick, release_tick, evt_tick SHALL each be high for exactly one cycle per event, never two consecutive cycles except repeat when RATE_CNT==1.
REQ-023 Latency: press_tick one cycle after the edge sampling sw_db rise; first repeat exactly DELAY_CNT cycles after press_tick; then every RATE_CNT cycles.
REQ-024 sw_db high at reset release SHALL NOT generate press_tick (sw_q resets to 1 behaviour: rise requires an observed 0).
REQ-025 DELAY_CNT and RATE_CNT below 1 SHALL be illegal; elaboration-time check.

Reset
REQ-026 On resetM==1 at a rising edge: state IDLE, cnt 0, sw_q 1, all ticks 0, held 0, rep_cnt 0.
REQ-027 Reset mid-HOLD or mid-REPEAT SHALL abort with no release_tick; key still down after reset SHALL wait for a release then new rise.

Structure
REQ-028 State encoding localparams and default DELAY_CNT/RATE_CNT/CNT_W SHALL live in the shared constants package used by the input stages.
REQ-029 One sub-module is natural: tick_counter (loadable, enable, terminal-count flag, CNT_W wide), shared for HOLD and RATE timing.
REQ-030 Remaining logic (edge detect, FSM, rep_cnt) SHALL be inline; target 120-250 lines.

Verification (DELAY_CNT=8, RATE_CNT=4, en=1 unless stated)
REQ-031 sw_db 0->1 at cycle 0, held -> press_tick and evt_tick at cycle 1; evt_tick at 9, 13, 17; held high from 9; rep_cnt 1,2,3.
REQ-032 sw_db high cycles 0-4 then low -> press_tick at 1, release_tick at 6, no repeat, rep_cnt 0.
REQ-033 en=0, key held 20 cycles -> single press_tick, no repeats, held 0; en->1 at cycle 20 -> evt_tick at 21, held 1.
REQ-034 Release coinciding with repeat due cycle (drop sw_db so fall sampled at cycle 12) -> release_tick at 13, no evt_tick at 13.
REQ-035 sw_db high through reset release -> no press_tick; drop then raise -> press_tick one cycle after rise sample.
REQ-036 Hold key 1100 cycles -> rep_cnt stops at 255, evt_tick keeps pulsing every 4 cycles.

Source files
------------

// File: rtl/key_autorepeat_pkg.sv
// rtl/key_autorepeat_pkg.sv - shared constants for the key input stages
//
// Purpose: default timing parameters, FSM state encoding and a saturating
//          increment helper shared by the key input stages.
// Ports:   none (package).

package key_autorepeat_pkg;

  // Defaults assume a 100 MHz clock: 500 ms before the first repeat, 100 ms between repeats.
  localparam int DEF_DELAY_CNT = 50_000_000;
  localparam int DEF_RATE_CNT  = 10_000_000;
  localparam int DEF_CNT_W     = 26;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_HOLD_ENC   = 2'd1;
  localparam logic [1:0] ST_REPEAT_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_HOLD   = ST_HOLD_ENC,
    ST_REPEAT = ST_REPEAT_ENC
  } ar_state_t;

  // Saturating 8-bit increment: the count sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/key_autorepeat_tick_counter.sv
// rtl/key_autorepeat_tick_counter.sv - clearable up-counter with terminal-count flag
//
// Purpose: counts enabled cycles up to a run-time limit and holds there;
//          used for both the initial hold delay and the repeat period.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   clear  in   load zero (wins over inc)
//   inc    in   count up by one unless already at limit
//   limit  in   terminal value
//   count  out  current count
//   tc     out  count == limit

module key_autorepeat_tick_counter #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  assign tc = (count == limit);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/key_autorepeat.sv
// rtl/key_autorepeat.sv - key press/release events with hold-to-repeat
//
// Purpose: turns a debounced key level into press, release and event
//          pulses; while held (and enabled) it emits a repeat event after
//          DELAY_CNT cycles and then every RATE_CNT cycles.
// Ports:
//   reloj         in   system clock, rising edge
//   resetM        in   synchronous active-high reset
//   sw_db         in   debounced key level, synchronous to reloj
//   en            in   auto-repeat enable
//   evt_tick      out  one-cycle pulse per press and per repeat
//   press_tick    out  one-cycle pulse on key press
//   release_tick  out  one-cycle pulse on key release
//   held          out  high while repeating
//   rep_cnt       out  repeats since the last press, saturating at 255

module key_autorepeat
  import key_autorepeat_pkg::*;
#(
  parameter int DELAY_CNT = DEF_DELAY_CNT,
  parameter int RATE_CNT  = DEF_RATE_CNT,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic       sw_db,
  input  logic       en,
  output logic       evt_tick,
  output logic       press_tick,
  output logic       release_tick,
  output logic       held,
  output logic [7:0] rep_cnt
);

  if (DELAY_CNT < 1) begin : g_bad_delay
    $error("key_autorepeat: DELAY_CNT must be at least 1");
  end
  if (RATE_CNT < 1) begin : g_bad_rate
    $error("key_autorepeat: RATE_CNT must be at least 1");
  end
  if (((64'(DELAY_CNT - 1) >> CNT_W) != 0) || ((64'(RATE_CNT - 1) >> CNT_W) != 0)) begin : g_bad_width
    $error("key_autorepeat: CNT_W too narrow for DELAY_CNT/RATE_CNT");
  end

  localparam logic [CNT_W-1:0] DELAY_LIM = CNT_W'(DELAY_CNT - 1);
  localparam logic [CNT_W-1:0] RATE_LIM  = CNT_W'(RATE_CNT - 1);

  ar_state_t        state;
  logic             sw_q;
  logic             rise;
  logic             cnt_clear;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_limit;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tc;

  // sw_q resets high so a key already down at reset is never taken as a press.
  assign rise = sw_db & ~sw_q;

  // One counter serves both phases; its limit follows the state.
  always_comb begin
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    cnt_limit = (state == ST_REPEAT) ? RATE_LIM : DELAY_LIM;
    case (state)
      ST_HOLD: begin
        if (!sw_db || (cnt_tc && en)) cnt_clear = 1'b1;
        else                          cnt_inc   = 1'b1;  // saturates at DELAY_LIM while en is low
      end
      ST_REPEAT: begin
        if (!sw_db)               cnt_clear = 1'b1;
        else if (!en)             cnt_inc   = 1'b0;      // paused: count held
        else if (cnt_tc)          cnt_clear = 1'b1;
        else                      cnt_inc   = 1'b1;
      end
      default: cnt_clear = 1'b1;
    endcase
  end

  key_autorepeat_tick_counter #(
    .CNT_W(CNT_W)
  ) u_tick_counter (
    .clk  (reloj),
    .rst  (resetM),
    .clear(cnt_clear),
    .inc  (cnt_inc),
    .limit(cnt_limit),
    .count(cnt),
    .tc   (cnt_tc)
  );

  always_ff @(posedge reloj) begin
    if (resetM) begin
      state        <= ST_IDLE;
      sw_q         <= 1'b1;
      evt_tick     <= 1'b0;
      press_tick   <= 1'b0;
      release_tick <= 1'b0;
      held         <= 1'b0;
      rep_cnt      <= 8'd0;
    end else begin
      sw_q         <= sw_db;
      evt_tick     <= 1'b0;
      press_tick   <= 1'b0;
      release_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state      <= ST_HOLD;
            press_tick <= 1'b1;
            evt_tick   <= 1'b1;
            rep_cnt    <= 8'd0;
          end
        end
        ST_HOLD: begin
          if (!sw_db) begin
            state        <= ST_IDLE;
            release_tick <= 1'b1;
          end else if (cnt_tc && en) begin
            state    <= ST_REPEAT;
            held     <= 1'b1;
            evt_tick <= 1'b1;
            rep_cnt  <= sat_inc8(rep_cnt);
          end
        end
        ST_REPEAT: begin
          // Release is checked first so a repeat due on the same edge is dropped.
          if (!sw_db) begin
            state        <= ST_IDLE;
            held         <= 1'b0;
            release_tick <= 1'b1;
          end else if (en && cnt_tc) begin
            evt_tick <= 1'b1;
            rep_cnt  <= sat_inc8(rep_cnt);
          end
        end
        default: begin
          state <= ST_IDLE;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule
